// File: rtl/pinky_pkg.sv
// Shared PinkyCGI definitions: data widths, opcode and condition-code encodings,
// plus small opcode classification helpers used by the execute/writeback stages.
package pinky_pkg;

  localparam int WORD    = 16;
  localparam int REG_IDX = 4;
  localparam logic [REG_IDX-1:0] PC_REG = 4'd15;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_ORR  = 5'd4,
    OP_EOR  = 5'd5,
    OP_BIC  = 5'd6,
    OP_MOV  = 5'd7,
    OP_NEG  = 5'd8,
    OP_MUL  = 5'd9,
    OP_SLT  = 5'd10,
    OP_SHA  = 5'd11,
    OP_LDR  = 5'd12,
    OP_STR  = 5'd13,
    OP_SYS  = 5'd14,
    OP_PRE  = 5'd15,
    OP_ADDF = 5'd16,
    OP_MULF = 5'd17,
    OP_RECF = 5'd18,
    OP_FTOI = 5'd19,
    OP_ITOF = 5'd20
  } opcode_e;

  // NE/EQ are resolved by decode; here they behave exactly like AL.
  typedef enum logic [1:0] {
    CC_AL = 2'd0,
    CC_S  = 2'd1,
    CC_NE = 2'd2,
    CC_EQ = 2'd3
  } cc_e;

  function automatic logic writes_reg(input opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_BIC, OP_MOV,
                      OP_NEG, OP_MUL, OP_SLT, OP_SHA, OP_LDR};
  endfunction

  function automatic logic is_fp_op(input opcode_e op);
    return op inside {OP_ADDF, OP_MULF, OP_RECF, OP_FTOI, OP_ITOF};
  endfunction

endpackage

// File: rtl/exec_writeback_if.sv
// Decoded-instruction bundle from decode plus the writeback/redirect signals
// returned to decode and fetch.
interface exec_writeback_if;
  import pinky_pkg::*;

  logic [WORD-1:0]    pc_in;
  logic [6:0]         op_cc_in;
  logic [WORD-1:0]    rd_val_in;
  logic [WORD-1:0]    op2_in;
  logic [REG_IDX-1:0] rd_idx_in;
  logic [REG_IDX-1:0] op2_idx_in;
  logic               op2_is_reg_in;

  logic               wr_en;
  logic [REG_IDX-1:0] wr_addr;
  logic [WORD-1:0]    wr_data;
  logic               z;
  logic               pc_load;
  logic [WORD-1:0]    pc_value;
  logic               fp_err;
  logic               halt;

  modport master (
    output pc_in, op_cc_in, rd_val_in, op2_in, rd_idx_in, op2_idx_in, op2_is_reg_in,
    input  wr_en, wr_addr, wr_data, z, pc_load, pc_value, fp_err, halt
  );

  modport slave (
    input  pc_in, op_cc_in, rd_val_in, op2_in, rd_idx_in, op2_idx_in, op2_is_reg_in,
    output wr_en, wr_addr, wr_data, z, pc_load, pc_value, fp_err, halt
  );

endinterface

// File: rtl/pinky_alu.sv
// Combinational integer ALU for the PinkyCGI execute stage (16-bit, wrapping).
module pinky_alu
  import pinky_pkg::*;
(
  input  opcode_e         op,
  input  logic [WORD-1:0] a,
  input  logic [WORD-1:0] b,
  output logic [WORD-1:0] result
);

  localparam int SH_W = $clog2(WORD);

  logic [WORD-1:0] shift_mag;
  logic [WORD-1:0] sha_result;

  // SHA takes b as a signed count: left for positive, arithmetic right for
  // negative, and any magnitude of WORD or more saturates.
  always_comb begin
    shift_mag  = b[WORD-1] ? (~b + 1'b1) : b;
    sha_result = '0;
    if (|shift_mag[WORD-1:SH_W]) begin
      sha_result = b[WORD-1] ? {WORD{a[WORD-1]}} : '0;
    end else if (b[WORD-1]) begin
      sha_result = $signed(a) >>> shift_mag[SH_W-1:0];
    end else begin
      sha_result = a << shift_mag[SH_W-1:0];
    end
  end

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_ORR:  result = a | b;
      OP_EOR:  result = a ^ b;
      OP_BIC:  result = a & ~b;
      OP_MOV:  result = b;
      OP_NEG:  result = '0 - b;
      OP_MUL:  result = a * b;
      OP_SLT:  result = {{(WORD-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHA:  result = sha_result;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/exec_writeback.sv
// PinkyCGI stages 2 and 3: execute with single-cycle bypass, data memory,
// register writeback, Z flag, R15 redirect with squash, and sticky halt/fp_err.
module exec_writeback
  import pinky_pkg::*;
#(
  parameter int DMEM_DEPTH = 65536
) (
  input logic clk,
  input logic reset,
  exec_writeback_if.slave bus
);

  localparam int ADDR_W = $clog2(DMEM_DEPTH);

  logic               s2_valid;
  opcode_e            s2_op;
  cc_e                s2_cc;
  logic [REG_IDX-1:0] s2_rd_idx;
  logic [REG_IDX-1:0] s2_op2_idx;
  logic               s2_op2_is_reg;
  logic [WORD-1:0]    s2_rd_val;
  logic [WORD-1:0]    s2_op2;

  logic               wr_en_q;
  logic [REG_IDX-1:0] wr_addr_q;
  logic [WORD-1:0]    wr_data_q;
  logic               z_q;
  logic               pc_load_q;
  logic [WORD-1:0]    pc_value_q;
  logic               fp_err_q;
  logic               halt_q;

  logic [WORD-1:0]    opa;
  logic [WORD-1:0]    opb;
  logic [WORD-1:0]    alu_result;
  logic [WORD-1:0]    commit_data;
  logic [ADDR_W-1:0]  mem_addr;
  logic               commit;

  logic [WORD-1:0]    dmem [DMEM_DEPTH];

  // A redirect or halt visible at this edge drops whatever decode offers.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= !(halt_q || pc_load_q);
    end
  end

  always_ff @(posedge clk) begin
    s2_op         <= opcode_e'(bus.op_cc_in[6:2]);
    s2_cc         <= cc_e'(bus.op_cc_in[1:0]);
    s2_rd_idx     <= bus.rd_idx_in;
    s2_op2_idx    <= bus.op2_idx_in;
    s2_op2_is_reg <= bus.op2_is_reg_in;
    s2_rd_val     <= bus.rd_val_in;
    s2_op2        <= bus.op2_in;
  end

  // The S3 result is one write newer than decode's regfile, so it overrides
  // the operands read there; an S2 instruction behind a redirect never commits.
  always_comb begin
    opa = s2_rd_val;
    opb = s2_op2;
    if (wr_en_q && (wr_addr_q == s2_rd_idx)) begin
      opa = wr_data_q;
    end
    if (s2_op2_is_reg && wr_en_q && (wr_addr_q == s2_op2_idx)) begin
      opb = wr_data_q;
    end
    mem_addr = opb[ADDR_W-1:0];
    commit   = s2_valid && !halt_q && !pc_load_q;
  end

  pinky_alu u_alu (
    .op     (s2_op),
    .a      (opa),
    .b      (opb),
    .result (alu_result)
  );

  always_comb begin
    commit_data = alu_result;
    if (s2_op == OP_LDR) begin
      commit_data = dmem[mem_addr];
    end
  end

  // Data memory is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (!reset && commit && (s2_op == OP_STR)) begin
      dmem[mem_addr] <= opa;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      z_q        <= 1'b0;
      pc_load_q  <= 1'b0;
      pc_value_q <= '0;
      fp_err_q   <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      pc_load_q <= 1'b0;
      if (commit) begin
        if (writes_reg(s2_op)) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= s2_rd_idx;
          wr_data_q <= commit_data;
          if (s2_cc == CC_S) begin
            z_q <= (commit_data == '0);
          end
          if (s2_rd_idx == PC_REG) begin
            pc_load_q  <= 1'b1;
            pc_value_q <= commit_data;
          end
        end
        if (s2_op == OP_SYS) begin
          halt_q <= 1'b1;
        end
        if (is_fp_op(s2_op)) begin
          fp_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.z        = z_q;
  assign bus.pc_load  = pc_load_q;
  assign bus.pc_value = pc_value_q;
  assign bus.fp_err   = fp_err_q;
  assign bus.halt     = halt_q;

endmodule

// File: tb/tb_exec_writeback.sv
// Bench for exec_writeback: acts as decode (stale regfile reads), runs directed
// and random instruction streams, and checks every commit against an ISA-level model.
module tb_exec_writeback;
  import pinky_pkg::*;

  typedef struct {
    logic [4:0]  op;
    logic [1:0]  cc;
    logic [3:0]  rd;
    logic [3:0]  op2_idx;
    logic        op2_is_reg;
    logic [15:0] imm;
  } instr_t;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        z;
    logic        pc_load;
    logic [15:0] pc_value;
    logic        halt;
    logic        fp_err;
  } expect_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  exec_writeback_if bus ();

  exec_writeback #(.DMEM_DEPTH(65536)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int num_compared = 0;
  int num_mismatched = 0;

  logic [15:0] regs [16];
  logic [15:0] prev_regs [16];
  logic [15:0] mem_m [32];
  logic        z_m, halt_m, fp_m;
  logic [15:0] pcv_m;
  int          squash;
  expect_t     exp_q [$];

  logic [4:0] op_list [20] = '{OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_BIC, OP_MOV,
                               OP_NEG, OP_MUL, OP_SLT, OP_SHA, OP_LDR, OP_STR, OP_NOP,
                               OP_PRE, OP_ADDF, OP_MULF, OP_RECF, OP_FTOI, OP_ITOF};

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    num_compared++;
    if (observed !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic compareExpect(input expect_t e);
    checkOutput("wr_en", 16'(bus.wr_en), 16'(e.wr_en));
    if (e.wr_en) begin
      checkOutput("wr_addr", 16'(bus.wr_addr), 16'(e.wr_addr));
      checkOutput("wr_data", bus.wr_data, e.wr_data);
    end
    checkOutput("z", 16'(bus.z), 16'(e.z));
    checkOutput("pc_load", 16'(bus.pc_load), 16'(e.pc_load));
    if (e.pc_load) checkOutput("pc_value", bus.pc_value, e.pc_value);
    checkOutput("halt", 16'(bus.halt), 16'(e.halt));
    checkOutput("fp_err", 16'(bus.fp_err), 16'(e.fp_err));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".wr_en"}, 16'(bus.wr_en), 16'd0);
    checkOutput({tag, ".wr_addr"}, 16'(bus.wr_addr), 16'd0);
    checkOutput({tag, ".wr_data"}, bus.wr_data, 16'd0);
    checkOutput({tag, ".z"}, 16'(bus.z), 16'd0);
    checkOutput({tag, ".pc_load"}, 16'(bus.pc_load), 16'd0);
    checkOutput({tag, ".pc_value"}, bus.pc_value, 16'd0);
    checkOutput({tag, ".halt"}, 16'(bus.halt), 16'd0);
    checkOutput({tag, ".fp_err"}, 16'(bus.fp_err), 16'd0);
  endtask

  function automatic logic [15:0] mdl_alu(input logic [4:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int     sa, sb, s, t;
    longint p;
    logic [15:0] r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = 16'h0;
    case (op)
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_AND: r = a & b;
      OP_ORR: r = a | b;
      OP_EOR: r = a ^ b;
      OP_BIC: r = a & ~b;
      OP_MOV: r = b;
      OP_NEG: r = 16'h0 - b;
      OP_MUL: begin p = longint'(a) * longint'(b); r = p[15:0]; end
      OP_SLT: r = (sa < sb) ? 16'd1 : 16'd0;
      OP_SHA: begin
        s = sb;
        if (s >= 16) r = 16'h0;
        else if (s >= 0) r = a << s;
        else if (s <= -16) r = (sa < 0) ? 16'hFFFF : 16'h0;
        else begin t = sa >>> (-s); r = t[15:0]; end
      end
      default: r = 16'h0;
    endcase
    return r;
  endfunction

  function automatic instr_t mk(input logic [4:0] op, input logic [1:0] cc,
                                input logic [3:0] rd, input logic is_reg,
                                input logic [3:0] idx, input logic [15:0] imm);
    instr_t i;
    i.op = op; i.cc = cc; i.rd = rd; i.op2_is_reg = is_reg; i.op2_idx = idx; i.imm = imm;
    return i;
  endfunction

  // Decode hands over regfile values missing the previous instruction's write;
  // the model executes in program order on the up-to-date architectural state.
  task automatic applyStimulus(input instr_t ins);
    logic [15:0] a, b, res;
    logic [15:0] saved [16];
    expect_t e;
    @(negedge clk);
    if (exp_q.size() == 2) compareExpect(exp_q.pop_front());
    bus.op_cc_in      = {ins.op, ins.cc};
    bus.rd_idx_in     = ins.rd;
    bus.rd_val_in     = prev_regs[ins.rd];
    bus.op2_idx_in    = ins.op2_idx;
    bus.op2_is_reg_in = ins.op2_is_reg;
    bus.op2_in        = ins.op2_is_reg ? prev_regs[ins.op2_idx] : ins.imm;
    bus.pc_in         = 16'($urandom);
    a = regs[ins.rd];
    b = ins.op2_is_reg ? regs[ins.op2_idx] : ins.imm;
    saved = regs;
    e.wr_en = 1'b0; e.wr_addr = 4'd0; e.wr_data = 16'd0; e.pc_load = 1'b0;
    if (halt_m) begin
    end else if (squash > 0) begin
      squash--;
    end else if (ins.op inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_BIC, OP_MOV,
                                OP_NEG, OP_MUL, OP_SLT, OP_SHA, OP_LDR}) begin
      res = (ins.op == OP_LDR) ? mem_m[b[4:0]] : mdl_alu(ins.op, a, b);
      regs[ins.rd] = res;
      e.wr_en = 1'b1; e.wr_addr = ins.rd; e.wr_data = res;
      if (ins.cc == CC_S) z_m = (res == 16'h0);
      if (ins.rd == 4'd15) begin e.pc_load = 1'b1; pcv_m = res; squash = 2; end
    end else if (ins.op == OP_STR) begin
      mem_m[b[4:0]] = a;
    end else if (ins.op == OP_SYS) begin
      halt_m = 1'b1;
    end else if (ins.op >= OP_ADDF && ins.op <= OP_ITOF) begin
      fp_m = 1'b1;
    end
    e.z = z_m; e.halt = halt_m; e.fp_err = fp_m; e.pc_value = pcv_m;
    exp_q.push_back(e);
    prev_regs = saved;
  endtask

  task automatic flushPipe();
    applyStimulus(mk(OP_NOP, 2'd0, 4'd0, 1'b0, 4'd0, 16'd0));
    applyStimulus(mk(OP_NOP, 2'd0, 4'd0, 1'b0, 4'd0, 16'd0));
    repeat (2) begin
      @(negedge clk);
      compareExpect(exp_q.pop_front());
    end
  endtask

  task automatic setReg(input int idx, input logic [15:0] val);
    regs[idx] = val;
    prev_regs[idx] = val;
  endtask

  // Injects one instruction the model never sees, then resets before it commits.
  task automatic resetMidStream(input string tag);
    @(negedge clk);
    bus.op_cc_in = {OP_ADD, CC_S}; bus.rd_idx_in = 4'd15; bus.rd_val_in = 16'h0011;
    bus.op2_in = 16'h0022; bus.op2_is_reg_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    bus.op_cc_in = {OP_NOP, CC_AL};
    @(negedge clk);
    checkAllZero(tag);
    reset = 1'b0;
    z_m = 1'b0; halt_m = 1'b0; fp_m = 1'b0; pcv_m = 16'd0; squash = 0;
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    int v;
    i.op = op_list[$urandom_range(0, 19)];
    i.cc = 2'($urandom_range(0, 3));
    i.rd = ($urandom_range(0, 31) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
    i.op2_is_reg = 1'($urandom_range(0, 1));
    i.op2_idx = 4'($urandom_range(0, 15));
    i.imm = 16'($urandom);
    if (i.op == OP_SHA && $urandom_range(0, 3) != 0) begin
      i.op2_is_reg = 1'b0;
      v = int'($urandom_range(0, 40)) - 20;
      i.imm = v[15:0];
    end
    if (i.op == OP_LDR || i.op == OP_STR) begin
      i.op2_is_reg = 1'b0;
      i.imm = 16'($urandom_range(0, 31));
    end
    if (i.op == OP_PRE) begin
      i.op2_is_reg = 1'b0;
      i.imm = 16'd0;
    end
    return i;
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    prev_regs = regs;
    z_m = 1'b0; halt_m = 1'b0; fp_m = 1'b0; pcv_m = 16'd0; squash = 0;
    reset = 1'b1;
    bus.pc_in = 16'd0; bus.op_cc_in = {OP_NOP, CC_AL}; bus.rd_val_in = 16'd0;
    bus.op2_in = 16'd0; bus.rd_idx_in = 4'd0; bus.op2_idx_in = 4'd0; bus.op2_is_reg_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;

    $display("[TB] ADD/SUB with Z flag");
    setReg(1, 16'd5);
    applyStimulus(mk(OP_ADD, CC_S, 4'd1, 1'b0, 4'd0, 16'd3));
    applyStimulus(mk(OP_SUB, CC_S, 4'd1, 1'b0, 4'd0, 16'd8));
    flushPipe();

    $display("[TB] back-to-back bypass");
    setReg(2, 16'd4);
    applyStimulus(mk(OP_ADD, CC_AL, 4'd2, 1'b1, 4'd2, 16'd0));
    applyStimulus(mk(OP_ADD, CC_AL, 4'd3, 1'b1, 4'd2, 16'd0));
    flushPipe();

    $display("[TB] STR then LDR");
    setReg(4, 16'h1234);
    applyStimulus(mk(OP_STR, CC_AL, 4'd4, 1'b0, 4'd0, 16'h0010));
    applyStimulus(mk(OP_LDR, CC_S, 4'd5, 1'b0, 4'd0, 16'h0010));
    flushPipe();

    $display("[TB] R15 redirect and squash");
    applyStimulus(mk(OP_MOV, CC_AL, 4'd15, 1'b0, 4'd0, 16'h0020));
    applyStimulus(mk(OP_ADD, CC_AL, 4'd1, 1'b0, 4'd0, 16'd1));
    applyStimulus(mk(OP_ADD, CC_AL, 4'd2, 1'b0, 4'd0, 16'd1));
    applyStimulus(mk(OP_ADD, CC_AL, 4'd9, 1'b0, 4'd0, 16'd7));
    flushPipe();

    $display("[TB] SHA and SLT boundaries");
    setReg(6, 16'h8000);
    setReg(7, 16'h8000);
    setReg(8, 16'hFFFF);
    applyStimulus(mk(OP_SHA, CC_AL, 4'd6, 1'b0, 4'd0, 16'hFFFC));
    applyStimulus(mk(OP_SHA, CC_S, 4'd7, 1'b0, 4'd0, 16'h0001));
    applyStimulus(mk(OP_SLT, CC_S, 4'd8, 1'b0, 4'd0, 16'h0001));
    applyStimulus(mk(OP_SHA, CC_AL, 4'd10, 1'b0, 4'd0, 16'h8000));
    flushPipe();

    $display("[TB] random stream");
    for (int a = 0; a < 32; a++)
      applyStimulus(mk(OP_STR, CC_AL, 4'($urandom_range(0, 14)), 1'b0, 4'd0, 16'(a)));
    for (int n = 0; n < 300; n++) applyStimulus(rand_instr());
    flushPipe();

    $display("[TB] SYS halt then reset");
    applyStimulus(mk(OP_SYS, CC_AL, 4'd0, 1'b0, 4'd0, 16'd0));
    applyStimulus(mk(OP_ADD, CC_S, 4'd1, 1'b0, 4'd0, 16'd1));
    applyStimulus(mk(OP_STR, CC_AL, 4'd1, 1'b0, 4'd0, 16'd3));
    applyStimulus(mk(OP_MOV, CC_AL, 4'd15, 1'b0, 4'd0, 16'h0040));
    flushPipe();
    resetMidStream("halt_reset");
    applyStimulus(mk(OP_LDR, CC_S, 4'd9, 1'b0, 4'd0, 16'd3));
    for (int n = 0; n < 100; n++) applyStimulus(rand_instr());
    flushPipe();

    $display("[TB] reset with instruction in flight");
    resetMidStream("flight_reset");
    for (int n = 0; n < 50; n++) applyStimulus(rand_instr());
    flushPipe();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
